// File: rtl/relay_sequencer.sv
// Relay coil sequencer: full-drive pull-in, PWM hold, enforced off time,
// and a fault counter that locks the relay out after repeated fault openings.
module relay_sequencer #(
    parameter int PULL_CYCLES    = 20000,
    parameter int HOLD_PERIOD    = 16,
    parameter int HOLD_ON        = 8,
    parameter int MIN_OFF_CYCLES = 2000,
    parameter int MAX_RETRIES    = 4,
    parameter int GOOD_CYCLES    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       relay_req,
    input  logic       fault,
    input  logic       clear_lockout,
    output logic       coil_drive,
    output logic       relay_closed,
    output logic       lockout,
    output logic [3:0] fault_count
);

    localparam int PW = (PULL_CYCLES    > 1) ? $clog2(PULL_CYCLES)    : 1;
    localparam int HW = (HOLD_PERIOD    > 1) ? $clog2(HOLD_PERIOD)    : 1;
    localparam int OW = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;
    localparam int GW = (GOOD_CYCLES    > 1) ? $clog2(GOOD_CYCLES)    : 1;

    localparam logic [PW-1:0] PULL_LAST = PW'(PULL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIOD - 1);
    localparam logic [HW:0]   HOLD_ON_V = (HW + 1)'(HOLD_ON);
    localparam logic [OW-1:0] OFF_LAST  = OW'(MIN_OFF_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_CYCLES - 1);
    localparam logic [4:0]    RETRY_LIM = 5'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_PULL,
        ST_HOLD,
        ST_OFF_WAIT,
        ST_LOCKOUT
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] pull_cnt;
    logic [HW-1:0] phase, phase_next;
    logic [OW-1:0] off_cnt;
    logic [GW-1:0] good_cnt;
    logic          good_done;
    logic          coil_next, closed_next, lockout_next;
    logic          energized, exit_now, exit_fault, good_hit, lock_clear;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    assign energized  = (state == ST_PULL) || (state == ST_HOLD);
    assign exit_now   = energized && (fault || !relay_req);
    assign exit_fault = energized && fault;
    assign good_hit   = (state == ST_HOLD) && (state_next == ST_HOLD) &&
                        !good_done && (good_cnt == GOOD_LAST);
    assign lock_clear = (state == ST_LOCKOUT) && (state_next == ST_OPEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OPEN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_OPEN:     if (relay_req && !fault) state_next = ST_PULL;
            ST_PULL:     if (exit_now) state_next = ST_OFF_WAIT;
                         else if (pull_cnt == PULL_LAST) state_next = ST_HOLD;
            ST_HOLD:     if (exit_now) state_next = ST_OFF_WAIT;
            ST_OFF_WAIT: if (off_cnt == OFF_LAST)
                             state_next = ({1'b0, fault_count} >= RETRY_LIM) ? ST_LOCKOUT : ST_OPEN;
            ST_LOCKOUT:  if (clear_lockout && !fault) state_next = ST_OPEN;
            default:     state_next = ST_OPEN;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_comb begin
        phase_next = '0;
        if (state_next == ST_HOLD && state == ST_HOLD)
            phase_next = (phase == HOLD_LAST) ? '0 : phase + HW'(1);
        coil_next    = (state_next == ST_PULL) ||
                       ((state_next == ST_HOLD) && ({1'b0, phase_next} < HOLD_ON_V));
        closed_next  = (state_next == ST_HOLD);
        lockout_next = (state_next == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pull_cnt     <= '0;
            phase        <= '0;
            off_cnt      <= '0;
            good_cnt     <= '0;
            good_done    <= 1'b0;
            fault_count  <= 4'd0;
            coil_drive   <= 1'b0;
            relay_closed <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            pull_cnt <= (state == ST_PULL && state_next == ST_PULL) ? pull_cnt + PW'(1) : '0;
            phase    <= phase_next;
            off_cnt  <= (state == ST_OFF_WAIT && state_next == ST_OFF_WAIT) ? off_cnt + OW'(1) : '0;

            // The good counter stops once it fires so the clear happens once per HOLD entry.
            if (state == ST_HOLD && state_next == ST_HOLD) begin
                if (!good_done) begin
                    if (good_cnt == GOOD_LAST) good_done <= 1'b1;
                    else                       good_cnt  <= good_cnt + GW'(1);
                end
            end else begin
                good_cnt  <= '0;
                good_done <= 1'b0;
            end

            if (exit_fault)                 fault_count <= sat_inc(fault_count);
            else if (good_hit || lock_clear) fault_count <= 4'd0;

            coil_drive   <= coil_next;
            relay_closed <= closed_next;
            lockout      <= lockout_next;
        end
    end

endmodule

// File: tb/tb_relay_sequencer.sv
// Scoreboard bench for relay_sequencer: an elapsed-time reference model predicts
// the registered outputs of every clock; a monitor compares them one edge later.
module tb_relay_sequencer;

    localparam int PULL_CYCLES    = 10;
    localparam int HOLD_PERIOD    = 4;
    localparam int HOLD_ON        = 1;
    localparam int MIN_OFF_CYCLES = 5;
    localparam int MAX_RETRIES    = 2;
    localparam int GOOD_CYCLES    = 40;

    localparam int M_OPEN = 0, M_PULL = 1, M_HOLD = 2, M_OFF = 3, M_LOCK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       relay_req, fault, clear_lockout;
    logic       coil_drive, relay_closed, lockout;
    logic [3:0] fault_count;

    typedef struct packed {
        logic       coil;
        logic       closed;
        logic       lock;
        logic [3:0] fcnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    int   checks = 0;
    int   errors = 0;

    int m_mode, m_since, m_fcnt;

    relay_sequencer #(
        .PULL_CYCLES(PULL_CYCLES), .HOLD_PERIOD(HOLD_PERIOD), .HOLD_ON(HOLD_ON),
        .MIN_OFF_CYCLES(MIN_OFF_CYCLES), .MAX_RETRIES(MAX_RETRIES), .GOOD_CYCLES(GOOD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .relay_req(relay_req), .fault(fault),
        .clear_lockout(clear_lockout), .coil_drive(coil_drive),
        .relay_closed(relay_closed), .lockout(lockout), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.coil   = (m_mode == M_PULL) ||
                   ((m_mode == M_HOLD) && ((m_since % HOLD_PERIOD) < HOLD_ON));
        e.closed = (m_mode == M_HOLD);
        e.lock   = (m_mode == M_LOCK);
        e.fcnt   = 4'(m_fcnt);
        return e;
    endfunction

    task automatic model_reset();
        m_mode = M_OPEN; m_since = 0; m_fcnt = 0;
    endtask

    // Advance the model across one rising edge with the given input samples.
    task automatic model_step(input logic req, input logic flt, input logic clr);
        case (m_mode)
            M_OPEN: if (req && !flt) begin m_mode = M_PULL; m_since = 0; end
            M_PULL, M_HOLD: begin
                if (flt || !req) begin
                    if (flt && m_fcnt < 15) m_fcnt++;
                    m_mode = M_OFF; m_since = 0;
                end else begin
                    m_since++;
                    if (m_mode == M_PULL && m_since == PULL_CYCLES) begin
                        m_mode = M_HOLD; m_since = 0;
                    end else if (m_mode == M_HOLD && m_since == GOOD_CYCLES) begin
                        m_fcnt = 0;
                    end
                end
            end
            M_OFF: begin
                m_since++;
                if (m_since == MIN_OFF_CYCLES) begin
                    m_mode  = (m_fcnt >= MAX_RETRIES) ? M_LOCK : M_OPEN;
                    m_since = 0;
                end
            end
            M_LOCK: if (clr && !flt) begin m_mode = M_OPEN; m_fcnt = 0; end
            default: m_mode = M_OPEN;
        endcase
    endtask

    task automatic cycle(input logic req, input logic flt, input logic clr);
        @(negedge clk);
        relay_req = req; fault = flt; clear_lockout = clr;
        model_step(req, flt, clr);
        q.push_back(model_out());
        @(posedge clk);
    endtask

    task automatic repeat_cycle(input int n, input logic req, input logic flt, input logic clr);
        for (int i = 0; i < n; i++) cycle(req, flt, clr);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Spot check a short time after the edge, once the registered outputs have settled.
    task automatic spot(input string name, input int act_sel, input int exp);
        #2;
        case (act_sel)
            0: check(name, int'(coil_drive), exp);
            1: check(name, int'(relay_closed), exp);
            2: check(name, int'(lockout), exp);
            default: check(name, int'(fault_count), exp);
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = {coil_drive, relay_closed, lockout, fault_count};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual coil=%b closed=%b lock=%b fcnt=%0d required coil=%b closed=%b lock=%b fcnt=%0d",
                         $time, mon_a.coil, mon_a.closed, mon_a.lock, mon_a.fcnt,
                         mon_e.coil, mon_e.closed, mon_e.lock, mon_e.fcnt);
            end
        end
    end

    initial begin
        logic req_r;
        rst = 1'b1; relay_req = 1'b0; fault = 1'b0; clear_lockout = 1'b0;
        model_reset();
        #1;
        check("reset_coil", int'(coil_drive), 0);
        check("reset_closed", int'(relay_closed), 0);
        check("reset_lockout", int'(lockout), 0);
        check("reset_fcnt", int'(fault_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);

        // Close: 10 cycles full drive, then 1,0,0,0 hold pattern.
        repeat_cycle(10, 1, 0, 0);
        spot("pull_last_coil", 0, 1);
        spot("pull_last_open", 1, 0);
        cycle(1, 0, 0);
        spot("hold_first_closed", 1, 1);
        repeat_cycle(20, 1, 0, 0);

        // Request drop in HOLD: no fault counted.
        cycle(0, 0, 0);
        spot("drop_coil", 0, 0);
        repeat_cycle(8, 0, 0, 0);
        spot("drop_fcnt", 3, 0);

        // Two fault pulses during PULL lead to lockout.
        repeat_cycle(3, 1, 0, 0);
        cycle(1, 1, 0);
        spot("fault1_fcnt", 3, 1);
        repeat_cycle(9, 1, 0, 0);
        cycle(1, 1, 0);
        spot("fault2_fcnt", 3, 2);
        repeat_cycle(8, 1, 0, 0);
        spot("lockout_set", 2, 1);
        spot("lockout_coil", 0, 0);

        // Clear is refused while fault is high, accepted once it is low.
        repeat_cycle(2, 1, 1, 1);
        spot("clear_blocked", 2, 1);
        cycle(1, 0, 1);
        spot("clear_ok_lock", 2, 0);
        spot("clear_ok_fcnt", 3, 0);
        repeat_cycle(5, 1, 0, 0);
        spot("reclose_coil", 0, 1);

        // One fault, then 40 unbroken HOLD cycles clear the count.
        cycle(1, 1, 0);
        repeat_cycle(55, 1, 0, 0);
        spot("good_before", 3, 1);
        cycle(1, 0, 0);
        spot("good_after", 3, 0);
        repeat_cycle(10, 1, 0, 0);

        // Fault together with drop counts once; then reset in the middle of PULL.
        cycle(0, 1, 0);
        spot("fault_drop_fcnt", 3, 1);
        repeat_cycle(9, 1, 0, 0);
        spot("prereset_coil", 0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_coil", int'(coil_drive), 0);
        check("async_closed", int'(relay_closed), 0);
        check("async_lockout", int'(lockout), 0);
        check("async_fcnt", int'(fault_count), 0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        relay_req = 1'b0; fault = 1'b0; clear_lockout = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        cycle(1, 0, 0);
        spot("post_reset_pull", 0, 1);

        // Randomised traffic with a sticky request and rare faults.
        req_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) req_r = ~req_r;
            cycle(req_r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
        end

        #3;
        check("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relay_sequencer.md
RELAY_SEQUENCER -- requirements
Module: relay_sequencer

Interface
REQ-001 SHALL have parameter PULL_CYCLES, default 20000, cycles of full coil drive after close command (10 ms at 2 MHz).
REQ-002 SHALL have parameter HOLD_PERIOD, default 16, hold-phase PWM period in cycles (2..256).
REQ-003 SHALL have parameter HOLD_ON, default 8, high cycles per hold period (1..HOLD_PERIOD).
REQ-004 SHALL have parameter MIN_OFF_CYCLES, default 2000, minimum coil-off time before re-close (>=1).
REQ-005 SHALL have parameter MAX_RETRIES, default 4, fault-caused openings before lockout (1..15).
REQ-006 SHALL have parameter GOOD_CYCLES, default 200000, continuous HOLD cycles that clear fault_count.
REQ-007 SHALL have port clk, input, 1 bit: the single clock for all logic (2 MHz fabric clock).
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port relay_req, input, 1 bit: close request from the protection controller (level).
REQ-010 SHALL have port fault, input, 1 bit: input-disable / out-of-range flag (level, synchronous to clk).
REQ-011 SHALL have port clear_lockout, input, 1 bit: single-cycle operator clear pulse.
REQ-012 SHALL have port coil_drive, output, 1 bit: relay coil transistor gate, registered.
REQ-013 SHALL have port relay_closed, output, 1 bit: high only in HOLD, registered.
REQ-014 SHALL have port lockout, output, 1 bit: high only in LOCKOUT, registered.
REQ-015 SHALL have port fault_count, output, 4 bits: fault-caused openings since last clear, registered.

Function
REQ-016 SHALL implement states OPEN, PULL, HOLD, OFF_WAIT, LOCKOUT; all transitions on rising clk, inputs sampled same edge.
REQ-017 SHALL, in OPEN, move to PULL when relay_req=1 and fault=0; else remain.
REQ-018 SHALL hold coil_drive=1 for every PULL cycle, PULL lasting exactly PULL_CYCLES cycles, then enter HOLD.
REQ-019 SHALL, in HOLD, run phase counter 0..HOLD_PERIOD-1 starting at 0 on entry, wrapping; coil_drive=1 iff phase<HOLD_ON.
REQ-020 SHALL, in PULL or HOLD, enter OFF_WAIT on the edge where fault=1 or relay_req=0; coil_drive=0 from that edge.
REQ-021 SHALL increment fault_count (saturating at 15) on a PULL/HOLD exit with fault=1; relay_req drop alone does not count; fault and drop together counts once.
REQ-022 SHALL hold coil_drive=0 in OFF_WAIT for exactly MIN_OFF_CYCLES cycles, then enter LOCKOUT if fault_count>=MAX_RETRIES, else OPEN.
REQ-023 SHALL ignore relay_req and fault during OFF_WAIT (no early exit, no counting).
REQ-024 SHALL count consecutive HOLD cycles; on reaching GOOD_CYCLES, clear fault_count to 0 (once per HOLD entry); counter zeroes on HOLD exit.
REQ-025 SHALL, in LOCKOUT, hold coil_drive=0 and exit to OPEN with fault_count=0 only when clear_lockout=1 and fault=0.
REQ-026 SHALL ignore clear_lockout outside LOCKOUT.
REQ-027 SHALL size all counters to the ceiling log2 of their parameter; no counter wraps except the HOLD phase counter.
REQ-028 SHALL never assert coil_drive in OPEN, OFF_WAIT or LOCKOUT.

Reset
REQ-029 SHALL, on rst=1, immediately (no clock) force state OPEN, coil_drive=0, relay_closed=0, lockout=0, fault_count=0, all counters 0.
REQ-030 SHALL, after rst deasserts mid-operation, need a fresh relay_req sample in OPEN before the coil is driven.

Verification (PULL_CYCLES=10, HOLD_PERIOD=4, HOLD_ON=1, MIN_OFF_CYCLES=5, MAX_RETRIES=2, GOOD_CYCLES=40)
REQ-031 SHALL cover: relay_req=1, fault=0 -> coil_drive high 10 cycles, then pattern 1,0,0,0 repeating, relay_closed=1 from cycle 11.
REQ-032 SHALL cover: relay_req dropped in HOLD -> coil_drive=0 next edge, 5 OFF_WAIT cycles, OPEN, fault_count stays 0.
REQ-033 SHALL cover: fault pulse in PULL twice with relay_req held -> fault_count 1 then 2, LOCKOUT after second OFF_WAIT, lockout=1, coil stays 0.
REQ-034 SHALL cover: clear_lockout with fault=1 -> remains LOCKOUT; with fault=0 -> OPEN, fault_count=0, re-close follows.
REQ-035 SHALL cover: one fault, then 40 uninterrupted HOLD cycles -> fault_count returns 0.
REQ-036 SHALL cover: rst asserted mid-PULL -> coil_drive=0 asynchronously, all outputs at reset values.
